if_id_stage: RTL and testbench

- IF/ID pipeline register of the 32-bit MIPS processor, between instruction fetch and decode.
- Accepts the fetched instruction word and its PC via a valid/ready handshake and buffers up to two entries, so the upstream ready is purely registered.
- Presents the split instruction fields and PC+4 to decode. Its imm16 output feeds the 16-to-32 sign extender directly.

---
 rtl/mips_pkg.sv | 16 +
 rtl/pipe_skid_buffer.sv | 64 ++++++
 rtl/if_id_stage.sv | 57 +++++
 tb/tb_if_id_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS constants and the IF/ID entry layout.
package mips_pkg;
    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int IMM_W    = 16;
    localparam int JADDR_W  = 26;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } if_id_entry_t;
endpackage

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready register (main + skid) with registered in_ready and sync flush.
module pipe_skid_buffer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic [WIDTH-1:0] main_q, skid_q;
    logic             main_vld, skid_vld, skid_vld_n;
    logic             accept, xfer, main_free;

    assign accept    = in_valid && in_ready;
    assign xfer      = main_vld && out_ready;
    assign main_free = !main_vld || xfer;

    // A free main slot always absorbs the skid, so the skid only stays or fills when main is stuck.
    always_comb begin
        skid_vld_n = skid_vld;
        if (main_free)
            skid_vld_n = 1'b0;
        else if (accept)
            skid_vld_n = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            in_ready <= 1'b1;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            if (main_free) begin
                if (skid_vld) begin
                    main_q   <= skid_q;
                    main_vld <= 1'b1;
                end else if (accept) begin
                    main_q   <= in_data;
                    main_vld <= 1'b1;
                end else begin
                    main_vld <= 1'b0;
                end
            end else if (accept) begin
                skid_q <= in_data;
            end
            skid_vld <= skid_vld_n;
            in_ready <= !skid_vld_n;
        end
    end

    assign out_valid = main_vld;
    assign out_data  = main_q;
endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: buffers fetched instr with PC+4 and presents decoded fields.
module if_id_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_INC = 32'd4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [31:0]         in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [REG_W-1:0]    rd,
    output logic [REG_W-1:0]    shamt,
    output logic [5:0]          funct,
    output logic [IMM_W-1:0]    imm16,
    output logic [JADDR_W-1:0]  jaddr,
    output logic [31:0]         pc_plus4,
    output logic                is_rtype,
    output logic                is_jtype
);
    if_id_entry_t in_entry, out_entry;

    // Adder sits on the input side so decode sees a plain register output.
    assign in_entry.instr    = in_instr;
    assign in_entry.pc_plus4 = in_pc + PC_INC;

    pipe_skid_buffer #(.WIDTH($bits(if_id_entry_t))) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry)
    );

    assign opcode   = out_entry.instr[31:26];
    assign rs       = out_entry.instr[25:21];
    assign rt       = out_entry.instr[20:16];
    assign rd       = out_entry.instr[15:11];
    assign shamt    = out_entry.instr[10:6];
    assign funct    = out_entry.instr[5:0];
    assign imm16    = out_entry.instr[15:0];
    assign jaddr    = out_entry.instr[25:0];
    assign pc_plus4 = out_entry.pc_plus4;
    assign is_rtype = (opcode == OP_RTYPE);
    assign is_jtype = (opcode == OP_J) || (opcode == OP_JAL);
endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: expected entries queued on accept, checked at the head.
module tb_if_id_stage;
    logic        clk = 1'b0, reset = 1'b1, flush = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic        in_ready, out_valid, is_rtype, is_jtype;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] jaddr;
    logic [31:0] pc_plus4;

    int vectors = 0, miscompares = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    if_id_stage #(.PC_INC(32'd4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm16(imm16), .jaddr(jaddr), .pc_plus4(pc_plus4),
        .is_rtype(is_rtype), .is_jtype(is_jtype)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_head();
        logic [31:0] i, p4;
        logic [5:0]  op;
        chk("in_ready", in_ready, sb.size() < 2);
        chk("out_valid", out_valid, sb.size() != 0);
        if (sb.size() != 0) begin
            {i, p4} = sb[0];
            op = i[31:26];
            chk("opcode", opcode, op);
            chk("rs", rs, i[25:21]);
            chk("rt", rt, i[20:16]);
            chk("rd", rd, i[15:11]);
            chk("shamt", shamt, i[10:6]);
            chk("funct", funct, i[5:0]);
            chk("imm16", imm16, i[15:0]);
            chk("jaddr", jaddr, i[25:0]);
            chk("pc_plus4", pc_plus4, p4);
            chk("is_rtype", is_rtype, op == 6'h00);
            chk("is_jtype", is_jtype, op == 6'h02 || op == 6'h03);
        end
    endtask

    // Called 1 time unit after a rising edge; drives, checks, advances one cycle.
    task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p,
                        input logic ordy, input logic fl);
        logic acc, xf;
        in_valid = v; in_instr = i; in_pc = p; out_ready = ordy; flush = fl;
        #1;
        chk_head();
        if (fl) begin
            sb.delete();
        end else begin
            acc = v && (sb.size() < 2);
            xf  = ordy && (sb.size() != 0);
            if (xf) void'(sb.pop_front());
            if (acc) sb.push_back({i, p + 32'd4});
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_opcode"}, opcode, 6'h00);
        chk({tag, "_imm16"}, imm16, 16'h0);
        chk({tag, "_jaddr"}, jaddr, 26'h0);
        chk({tag, "_pc_plus4"}, pc_plus4, 32'h0);
        chk({tag, "_is_rtype"}, is_rtype, 1'b1);
        chk({tag, "_is_jtype"}, is_jtype, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("rst");
        reset = 1'b0;
        @(posedge clk); #1;
        chk_reset_state("rst_rel");

        // addi $t1,$t1,-1
        step(1, 32'h2129FFFF, 32'h00400000, 1, 0);
        chk("addi_valid", out_valid, 1'b1);
        chk("addi_opcode", opcode, 6'h08);
        chk("addi_rs", rs, 5'd9);
        chk("addi_rt", rt, 5'd9);
        chk("addi_imm", imm16, 16'hFFFF);
        chk("addi_pc4", pc_plus4, 32'h00400004);
        chk("addi_rtype", is_rtype, 1'b0);
        chk("addi_jtype", is_jtype, 1'b0);

        // add $t2,$t1,$t0
        step(1, 32'h01285020, 32'h00400004, 1, 0);
        chk("add_opcode", opcode, 6'h00);
        chk("add_rs", rs, 5'd9);
        chk("add_rt", rt, 5'd8);
        chk("add_rd", rd, 5'd10);
        chk("add_shamt", shamt, 5'd0);
        chk("add_funct", funct, 6'h20);
        chk("add_rtype", is_rtype, 1'b1);

        // j at the top of memory: pc_plus4 wraps
        step(1, 32'h08000100, 32'hFFFFFFFC, 1, 0);
        chk("j_jtype", is_jtype, 1'b1);
        chk("j_jaddr", jaddr, 26'h0000100);
        chk("j_pc4", pc_plus4, 32'h00000000);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Stall: A held, B into skid, C waits on in_ready
        step(1, 32'h8C880004, 32'h00001000, 0, 0);
        step(1, 32'h0C000040, 32'h00001004, 0, 0);
        chk("stall_rdy", in_ready, 1'b0);
        chk("stall_hold_a", opcode, 6'h23);
        step(1, 32'h00851022, 32'h00001008, 0, 0);
        step(1, 32'h00851022, 32'h00001008, 0, 0);
        chk("stall_hold_a2", pc_plus4, 32'h00001004);
        step(1, 32'h00851022, 32'h00001008, 1, 0);
        chk("drain_b", pc_plus4, 32'h00001008);
        step(1, 32'h00851022, 32'h00001008, 1, 0);
        chk("drain_c", pc_plus4, 32'h0000100C);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Flush with two buffered and one offered
        step(1, 32'h11110000, 32'h00002000, 0, 0);
        step(1, 32'h22220000, 32'h00002004, 0, 0);
        step(1, 32'h33330000, 32'h00002008, 0, 1);
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_rdy", in_ready, 1'b1);
        step(0, 32'h0, 32'h0, 1, 0);
        step(1, 32'h24420001, 32'h00002010, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Random traffic with occasional flush
        for (int n = 0; n < 200; n++)
            step(1'($urandom_range(0, 3) != 0), $urandom, {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));

        // Reset mid-stream: reset-state outputs before the next edge
        step(1, 32'h8C880004, 32'h00003000, 0, 0);
        step(1, 32'h0C000040, 32'h00003004, 0, 0);
        reset = 1'b1;
        #1;
        chk_reset_state("mid_rst");
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        step(0, 32'h0, 32'h0, 1, 0);
        step(1, 32'h01285020, 32'h00004000, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
